mmu_result_collector: RTL and testbench

Receive-side companion to the MMU datapath: accepts the 7-lane 32-bit accumulator beats the MMU emits on its `valid_out`/`mmu_out` interface, requantizes each lane to signed 8-bit, and buffers the beats in a FIFO. Results drain toward the activation/writeback path over a valid/ready handshake. The MMU output has no backpressure, so the block reports `almost_full` to the issue sequencer and sets a sticky `overflow` flag if a beat has to be dropped.

---
 rtl/mmu_pkg.sv | 21 ++
 rtl/mmu_result_fifo.sv | 34 +++
 rtl/mmu_result_collector.sv | 68 ++++++
 tb/tb_mmu_result_collector.sv | 164 ++++++++++++++++
 4 files changed

// File: rtl/mmu_pkg.sv
// mmu_pkg: shared MMU result types and the requant (shift/round/saturate) function.
// Define MMU_COLLECT_ROUND_EN for round-half-up; otherwise the shift truncates toward -inf.
package mmu_pkg;
  localparam int LANES = 7;
  localparam int ACC_W = 32;
  localparam int OUT_W = 8;
  typedef logic signed [ACC_W-1:0] acc_vec_t [LANES];
  typedef logic [LANES-1:0][OUT_W-1:0] q_vec_t;
  localparam logic signed [ACC_W:0] Q_MAX = (ACC_W+1)'((2 ** (OUT_W-1)) - 1);
  localparam logic signed [ACC_W:0] Q_MIN = (ACC_W+1)'(-(2 ** (OUT_W-1)));
  // One extra bit keeps the rounding add from wrapping at the accumulator maximum
  function automatic logic signed [OUT_W-1:0] requant(input logic signed [ACC_W-1:0] acc, input logic [4:0] shift);
    logic signed [ACC_W:0] s;
    s = (ACC_W+1)'(acc);
`ifdef MMU_COLLECT_ROUND_EN
    if (shift != 5'd0) s = s + ((ACC_W+1)'(1) << (shift - 5'd1));
`endif
    s = s >>> shift;
    return (s > Q_MAX) ? OUT_W'(Q_MAX) : (s < Q_MIN) ? OUT_W'(Q_MIN) : s[OUT_W-1:0];
  endfunction
endpackage

// File: rtl/mmu_result_fifo.sv
// mmu_result_fifo: synchronous FIFO with occupancy count; storage is never cleared, only pointers.
module mmu_result_fifo import mmu_pkg::*; #(
  parameter int DEPTH = 8,
  parameter int W = $bits(q_vec_t) + 1
) (
  input  logic clk,
  input  logic rst,
  input  logic wr,
  input  logic rd,
  input  logic [W-1:0] wdata,
  output logic [W-1:0] rdata,
  output logic full,
  output logic empty,
  output logic [$clog2(DEPTH):0] count
);
  localparam int AW = $clog2(DEPTH);
  logic [W-1:0] mem [DEPTH];
  logic [AW-1:0] wptr, rptr;
  assign rdata = mem[rptr];
  assign full = count == (AW+1)'(DEPTH);
  assign empty = count == '0;
  always_ff @(posedge clk)
    if (wr) mem[wptr] <= wdata;
  always_ff @(posedge clk)
    if (rst) begin
      wptr <= '0;
      rptr <= '0;
      count <= '0;
    end else begin
      wptr <= wptr + AW'(wr);
      rptr <= rptr + AW'(rd);
      count <= count + (AW+1)'(wr) - (AW+1)'(rd);
    end
endmodule

// File: rtl/mmu_result_collector.sv
// mmu_result_collector: requantizes MMU accumulator beats and buffers them for a valid/ready consumer.
// Rounding mode is chosen by MMU_COLLECT_ROUND_EN (see mmu_pkg::requant).
module mmu_result_collector #(
  parameter int LANES = mmu_pkg::LANES,
  parameter int ACC_W = mmu_pkg::ACC_W,
  parameter int OUT_W = mmu_pkg::OUT_W,
  parameter int DEPTH = 8,
  parameter int AF_MARGIN = 2,
  parameter int BEATS = 4
) (
  input  logic clk,
  input  logic rst,
  input  logic mmu_valid,
  input  logic [LANES*ACC_W-1:0] mmu_out,
  input  logic [4:0] shift,
  output logic out_valid,
  input  logic out_ready,
  output logic [LANES*OUT_W-1:0] out_data,
  output logic out_last,
  output logic almost_full,
  output logic overflow,
  output logic [$clog2(DEPTH):0] count
);
  localparam int CW = $clog2(DEPTH) + 1;
  localparam int BW = BEATS > 1 ? $clog2(BEATS) : 1;
  localparam int W = LANES*OUT_W + 1;
  logic pv, p_last, full, empty, wr, rd;
  logic [BW-1:0] beat_cnt;
  logic [LANES*OUT_W-1:0] q, p_q;
  logic [W-1:0] head;
  always_comb begin
    q = '0;
    for (int i = 0; i < LANES; i++) q[i*OUT_W +: OUT_W] = mmu_pkg::requant(mmu_out[i*ACC_W +: ACC_W], shift);
  end
  assign rd = out_valid && out_ready;
  assign wr = pv && (!full || rd);
  assign out_valid = !empty;
  assign out_data = out_valid ? head[W-1:1] : '0;
  assign out_last = out_valid && head[0];
  // beat_cnt advances on every accepted beat, even ones later dropped, to keep tile alignment
  always_ff @(posedge clk)
    if (rst) begin
      pv <= 1'b0;
      beat_cnt <= '0;
      almost_full <= 1'b0;
      overflow <= 1'b0;
    end else begin
      pv <= mmu_valid;
      if (mmu_valid) begin
        p_q <= q;
        p_last <= beat_cnt == BW'(BEATS-1);
        beat_cnt <= (beat_cnt == BW'(BEATS-1)) ? '0 : beat_cnt + 1'b1;
      end
      almost_full <= ({1'b0, count} + (CW+1)'(pv)) >= (CW+1)'(DEPTH - AF_MARGIN);
      if (pv && full && !rd) overflow <= 1'b1;
    end
  mmu_result_fifo #(.DEPTH(DEPTH), .W(W)) u_fifo (
    .clk(clk),
    .rst(rst),
    .wr(wr),
    .rd(rd),
    .wdata({p_q, p_last}),
    .rdata(head),
    .full(full),
    .empty(empty),
    .count(count)
  );
endmodule

// File: tb/tb_mmu_result_collector.sv
// tb_mmu_result_collector: directed self-checking bench for mmu_result_collector.
module tb_mmu_result_collector;
  localparam int LANES = 7, ACC_W = 32, OUT_W = 8, DEPTH = 8;
  logic clk = 1'b0, rst = 1'b1, mmu_valid = 1'b0, out_ready = 1'b0;
  logic [LANES*ACC_W-1:0] mmu_out = '0;
  logic [4:0] shift = 5'd1;
  logic out_valid, out_last, almost_full, overflow;
  logic [LANES*OUT_W-1:0] out_data;
  logic [$clog2(DEPTH):0] count;
  int checks = 0, failures = 0;
  always #5 clk = ~clk;
  mmu_result_collector #(.DEPTH(DEPTH), .AF_MARGIN(2), .BEATS(4)) dut (
    .clk(clk), .rst(rst), .mmu_valid(mmu_valid), .mmu_out(mmu_out), .shift(shift),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_last(out_last),
    .almost_full(almost_full), .overflow(overflow), .count(count)
  );
  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask
  task automatic tick;
    @(posedge clk);
    #1;
  endtask
  // Lane 0 carries 2*id so that a shift of 1 yields id in both rounding modes
  task automatic beat(input int id);
    mmu_valid = 1'b1;
    mmu_out = '0;
    mmu_out[ACC_W-1:0] = ACC_W'(2 * id);
  endtask
  task automatic do_reset;
    rst = 1'b1;
    mmu_valid = 1'b0;
    tick;
    tick;
    rst = 1'b0;
  endtask
  int acc [7] = '{5, -5, 1000, -1000, 0, 127, -129};
`ifdef MMU_COLLECT_ROUND_EN
  int qv [7] = '{3, -2, 127, -128, 0, 64, -64};
`else
  int qv [7] = '{2, -3, 127, -128, 0, 63, -65};
`endif
  int cnt_t [12] = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 8, 8, 8};
  int af_t [12] = '{0, 0, 0, 0, 0, 0, 1, 1, 1, 1, 1, 1};
  int ov_t [12] = '{0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1, 1};
  logic [LANES*OUT_W-1:0] qexp;
  int n;
  initial begin
    tick;
    tick;
    check("rst_valid", out_valid, 0);
    check("rst_data", out_data, 0);
    check("rst_last", out_last, 0);
    check("rst_af", almost_full, 0);
    check("rst_ovf", overflow, 0);
    check("rst_count", count, 0);
    rst = 1'b0;
    // requant vector and two-cycle latency
    out_ready = 1'b1;
    for (int i = 0; i < LANES; i++) begin
      mmu_out[i*ACC_W +: ACC_W] = ACC_W'(acc[i]);
      qexp[i*OUT_W +: OUT_W] = OUT_W'(qv[i]);
    end
    mmu_valid = 1'b1;
    tick;
    check("lat_t1_valid", out_valid, 0);
    mmu_valid = 1'b0;
    tick;
    check("lat_t2_valid", out_valid, 1);
    check("rq_data", out_data, qexp);
    check("rq_last", out_last, 0);
    check("lat_t2_count", count, 1);
    tick;
    check("lat_t3_valid", out_valid, 0);
    check("lat_t3_count", count, 0);
    check("lat_t3_data", out_data, 0);
    // reset mid-stream: 5 buffered, pv=1, beat_cnt nonzero
    out_ready = 1'b0;
    for (int k = 1; k <= 6; k++) begin
      beat(k);
      tick;
    end
    check("rm_pre_count", count, 5);
    rst = 1'b1;
    beat(7);
    tick;
    rst = 1'b0;
    check("rm_count", count, 0);
    check("rm_valid", out_valid, 0);
    check("rm_ovf", overflow, 0);
    beat(9);
    tick;
    mmu_valid = 1'b0;
    check("rm_ignored", count, 0);
    out_ready = 1'b1;
    tick;
    check("rm_next_valid", out_valid, 1);
    check("rm_next_data", out_data[7:0], 9);
    check("rm_next_last", out_last, 0);
    // tile boundary with back-to-back beats
    do_reset;
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        n++;
        check("tile_data", out_data[7:0], 64'(n));
        check("tile_last", out_last, 64'(n % 4 == 0));
      end
      if (c < 8) beat(c + 1);
      else mmu_valid = 1'b0;
      tick;
    end
    check("tile_beats", n, 8);
    // fill and overflow with no consumer
    do_reset;
    out_ready = 1'b0;
    for (int k = 1; k <= 12; k++) begin
      if (k <= 10) beat(k);
      else mmu_valid = 1'b0;
      tick;
      check("fill_count", count, 64'(cnt_t[k-1]));
      check("fill_af", almost_full, 64'(af_t[k-1]));
      check("fill_ovf", overflow, 64'(ov_t[k-1]));
    end
    out_ready = 1'b1;
    n = 0;
    for (int c = 0; c < 20; c++) begin
      if (out_valid) begin
        n++;
        check("drain_data", out_data[7:0], 64'(n));
        check("drain_last", out_last, 64'(n % 4 == 0));
      end
      tick;
    end
    check("drain_beats", n, 8);
    check("drain_count", count, 0);
    check("drain_ovf_sticky", overflow, 1);
    do_reset;
    check("ovf_cleared", overflow, 0);
    // full with simultaneous push and pop
    out_ready = 1'b0;
    for (int k = 1; k <= 9; k++) begin
      beat(k);
      tick;
    end
    check("full_count", count, 8);
    out_ready = 1'b1;
    for (int k = 10; k < 30; k++) begin
      check("full_order", out_data[7:0], 64'(k - 9));
      beat(k);
      tick;
      check("full_hold_count", count, 8);
      check("full_no_ovf", overflow, 0);
    end
    mmu_valid = 1'b0;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
